// File: rtl/fb_pkg.sv
// Shared types and helpers for the double-buffered LED-matrix framebuffer.
// Optional build macro FB_CLEAR_ON_SWAP_EN is consumed by fb_page_ctrl.
package fb_pkg;
    localparam int FB_DIM   = 16;
    localparam int FB_DEN_W = 2;

    typedef logic [1:0] den_t;
    typedef logic [7:0] pix_addr_t;

    typedef enum logic [1:0] {IDLE, SWAP_WAIT, CLEAR} fb_state_t;

    function automatic pix_addr_t pix_addr(input logic [3:0] row, input logic [3:0] col);
        return {row, col};
    endfunction
endpackage

// File: rtl/fb_page_ctrl_arb.sv
// Two-way round-robin arbiter: combinational one-hot-or-zero grant,
// pointer flips to the other requester after every grant.
module rr_arbiter2 (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic [1:0] req,
    output logic [1:0] gnt
);
    logic rr_ptr_q, rr_ptr_d;

    always_comb begin
        gnt      = 2'b00;
        rr_ptr_d = rr_ptr_q;
        if (en) begin
            case (req)
                2'b01:   gnt = 2'b01;
                2'b10:   gnt = 2'b10;
                2'b11:   gnt = rr_ptr_q ? 2'b10 : 2'b01;
                default: gnt = 2'b00;
            endcase
        end
        if (gnt[0])      rr_ptr_d = 1'b1;
        else if (gnt[1]) rr_ptr_d = 1'b0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) rr_ptr_q <= 1'b0;
        else     rr_ptr_q <= rr_ptr_d;
    end
endmodule

// File: rtl/fb_page_ctrl.sv
// Double-buffered framebuffer: arbitrated back-page writes, registered front-page
// reads, frame-aligned page swap. Define FB_CLEAR_ON_SWAP_EN to zero the new back page after each swap.
module fb_page_ctrl
    import fb_pkg::*;
#(
    parameter int DIM   = FB_DIM,
    parameter int DEN_W = FB_DEN_W,
    parameter int NREQ  = 2,
    localparam int AW   = $clog2(DIM)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NREQ-1:0]       req_valid,
    output logic [NREQ-1:0]       req_ready,
    input  logic [NREQ*AW-1:0]    req_row,
    input  logic [NREQ*AW-1:0]    req_col,
    input  logic [NREQ*DEN_W-1:0] req_den,
    input  logic                  swap_req,
    output logic                  swap_ack,
    input  logic                  frame_end,
    input  logic [AW-1:0]         rd_row,
    input  logic [AW-1:0]         rd_col,
    output logic [DEN_W-1:0]      rd_den,
    output logic                  front_sel,
    output logic                  busy
);
    logic [DEN_W-1:0] mem [2][DIM*DIM];

    fb_state_t        state_q, state_d;
    logic             front_sel_q, front_sel_d;
    logic             swap_ack_q, swap_ack_d;
    logic [DEN_W-1:0] rd_den_q;
    logic [1:0]       gnt;
    logic             wr_en;
    pix_addr_t        wr_addr;
    logic [DEN_W-1:0] wr_den;
    logic             sel;
`ifdef FB_CLEAR_ON_SWAP_EN
    pix_addr_t        clr_addr_q, clr_addr_d;
`endif

    // Reset gating keeps ready low while rst is asserted, ahead of any clock edge.
    rr_arbiter2 u_arb (
        .clk (clk),
        .rst (rst),
        .en  ((state_q == IDLE) && !rst),
        .req (req_valid[1:0]),
        .gnt (gnt)
    );

    assign sel = gnt[1];

    always_comb begin
        state_d     = state_q;
        front_sel_d = front_sel_q;
        swap_ack_d  = 1'b0;
        wr_en       = 1'b0;
        wr_addr     = pix_addr(req_row[sel*AW +: AW], req_col[sel*AW +: AW]);
        wr_den      = req_den[sel*DEN_W +: DEN_W];
`ifdef FB_CLEAR_ON_SWAP_EN
        clr_addr_d  = clr_addr_q;
`endif
        case (state_q)
            IDLE: begin
                wr_en = |gnt;
                if (swap_req) state_d = SWAP_WAIT;
            end
            SWAP_WAIT: begin
                if (frame_end) begin
                    front_sel_d = ~front_sel_q;
                    swap_ack_d  = 1'b1;
`ifdef FB_CLEAR_ON_SWAP_EN
                    state_d     = CLEAR;
                    clr_addr_d  = '0;
`else
                    state_d     = IDLE;
`endif
                end
            end
            CLEAR: begin
`ifdef FB_CLEAR_ON_SWAP_EN
                wr_en      = 1'b1;
                wr_addr    = clr_addr_q;
                wr_den     = '0;
                clr_addr_d = clr_addr_q + 1'b1;
                if (clr_addr_q == '1) state_d = IDLE;
`else
                state_d = IDLE;
`endif
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            front_sel_q <= 1'b0;
            swap_ack_q  <= 1'b0;
            rd_den_q    <= '0;
        end else begin
            state_q     <= state_d;
            front_sel_q <= front_sel_d;
            swap_ack_q  <= swap_ack_d;
            rd_den_q    <= mem[front_sel_q][pix_addr(rd_row, rd_col)];
        end
    end

`ifdef FB_CLEAR_ON_SWAP_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) clr_addr_q <= '0;
        else     clr_addr_q <= clr_addr_d;
    end
`endif

    // Page contents are deliberately not reset; only the back page is ever written.
    always_ff @(posedge clk) begin
        if (wr_en) mem[~front_sel_q][wr_addr] <= wr_den;
    end

    assign req_ready = gnt;
    assign swap_ack  = swap_ack_q;
    assign front_sel = front_sel_q;
    assign rd_den    = rd_den_q;
    assign busy      = (state_q == SWAP_WAIT) || (state_q == CLEAR);
endmodule

// File: tb/tb_fb_page_ctrl.sv
// Randomized bench for fb_page_ctrl with an abstract page/swap model checked every cycle.
module tb_fb_page_ctrl;
    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] req_valid, req_ready;
    logic [7:0] req_row, req_col;
    logic [3:0] req_den;
    logic       swap_req, swap_ack, frame_end, front_sel, busy;
    logic [3:0] rd_row, rd_col;
    logic [1:0] rd_den;

    int n_cmp = 0;
    int n_bad = 0;

`ifdef FB_CLEAR_ON_SWAP_EN
    localparam bit CLR_EN = 1'b1;
`else
    localparam bit CLR_EN = 1'b0;
`endif

    fb_page_ctrl dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_row(req_row), .req_col(req_col), .req_den(req_den),
        .swap_req(swap_req), .swap_ack(swap_ack), .frame_end(frame_end),
        .rd_row(rd_row), .rd_col(rd_col), .rd_den(rd_den),
        .front_sel(front_sel), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Model: which page is shown, what each pixel of each page holds (if known),
    // and where the controller is in the swap/clear sequence.
    int m_phase = 0;   // 0 idle, 1 waiting for frame boundary, 2 clearing
    int m_clr   = 0;
    int m_front = 0;
    int m_rr    = 0;
    int m_ack   = 0;
    int m_pg [2][256];
    bit m_kn [2][256];
    int rd_exp = 0;
    bit rd_kn  = 1'b1;

    always @(negedge clk) begin : model
        int g, a, i;
        if (rst) begin
            chk("rst_ready", req_ready, 0);
            chk("rst_ack", swap_ack, 0);
            chk("rst_front", front_sel, 0);
            chk("rst_busy", busy, 0);
            chk("rst_rd", rd_den, 0);
            m_phase = 0; m_front = 0; m_rr = 0; m_ack = 0; m_clr = 0;
            rd_exp = 0; rd_kn = 1'b1;
        end else begin
            g = 0;
            if (m_phase == 0) g = (req_valid == 2'b11) ? (m_rr != 0 ? 2 : 1) : int'(req_valid);
            chk("req_ready", req_ready, g);
            chk("swap_ack", swap_ack, m_ack);
            chk("front_sel", front_sel, m_front);
            chk("busy", busy, (m_phase != 0) ? 1 : 0);
            if (rd_kn) chk("rd_den", rd_den, rd_exp);

            a = int'(rd_row) * 16 + int'(rd_col);
            rd_kn  = m_kn[m_front][a];
            rd_exp = m_pg[m_front][a];
            if (g != 0) begin
                i = (g == 2) ? 1 : 0;
                a = int'(req_row[i*4 +: 4]) * 16 + int'(req_col[i*4 +: 4]);
                m_pg[1-m_front][a] = int'(req_den[i*2 +: 2]);
                m_kn[1-m_front][a] = 1'b1;
                m_rr = (g == 1) ? 1 : 0;
            end
            m_ack = 0;
            case (m_phase)
                0: if (swap_req) m_phase = 1;
                1: if (frame_end) begin
                    m_front = 1 - m_front;
                    m_ack   = 1;
                    m_phase = CLR_EN ? 2 : 0;
                    m_clr   = 0;
                end
                default: begin
                    m_pg[1-m_front][m_clr] = 0;
                    m_kn[1-m_front][m_clr] = 1'b1;
                    if (m_clr == 255) m_phase = 0;
                    m_clr++;
                end
            endcase
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        while (busy && n < 400) begin
            tick();
            n++;
        end
        if (n >= 400) chk(name, busy, 0);
    endtask

    initial begin : watchdog
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin : stim
        logic [1:0] gv;
        int cnt;
        int f0;
        rst = 1'b0; req_valid = '0; req_row = '0; req_col = '0; req_den = '0;
        swap_req = 1'b0; frame_end = 1'b0; rd_row = '0; rd_col = '0;
        #1 rst = 1'b1;
        repeat (3) tick();
        rst = 1'b0;
        repeat (3) tick();

        // Both requesters contend: grants alternate 01,10,01,10.
        req_valid = 2'b11; req_row = {4'd3, 4'd3}; req_col = {4'd5, 4'd5}; req_den = {2'd2, 2'd2};
        rd_row = 4'd3; rd_col = 4'd5;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("arb_alt", req_ready, (k % 2 == 0) ? 1 : 2);
            gv = req_ready;
            tick();
            for (int i = 0; i < 2; i++)
                if (gv[i]) begin
                    req_col[i*4 +: 4] = 4'd6;
                    req_den[i*2 +: 2] = 2'd1;
                end
        end
        req_valid = 2'b00;
        tick();

        // swap_req with a coincident frame_end must not swap.
        swap_req = 1'b1; frame_end = 1'b1;
        tick();
        swap_req = 1'b0; frame_end = 1'b0;
        @(negedge clk);
        chk("no_early_swap", front_sel, 0);
        chk("wait_busy", busy, 1);
        repeat (29) tick();
        frame_end = 1'b1;
        tick();
        frame_end = 1'b0;
        rd_row = 4'd3; rd_col = 4'd5;
        @(negedge clk);
        chk("swap_ack_pulse", swap_ack, 1);
        chk("front_after_swap", front_sel, 1);
        tick();
        rd_col = 4'd6;
        @(negedge clk);
        chk("rd_3_5", rd_den, 2);
        tick();
        @(negedge clk);
        chk("rd_3_6", rd_den, 1);
        tick();
        wait_idle("clear_timeout");

        // Extra swap_req while waiting is dropped: one ack, one toggle.
        f0 = int'(front_sel);
        swap_req = 1'b1; tick(); swap_req = 1'b0; tick();
        swap_req = 1'b1; tick(); swap_req = 1'b0;
        repeat (3) tick();
        frame_end = 1'b1; tick(); frame_end = 1'b0;
        cnt = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            cnt += int'(swap_ack);
            tick();
        end
        chk("single_ack", cnt, 1);
        chk("single_toggle", front_sel, 1 - f0);
        wait_idle("clear_timeout2");
        repeat (5) tick();
        @(negedge clk);
        chk("no_queued_swap", front_sel, 1 - f0);
        tick();

        // Asynchronous reset mid-CLEAR (or mid-SWAP_WAIT without clear).
        swap_req = 1'b1; tick(); swap_req = 1'b0;
        if (CLR_EN) begin
            frame_end = 1'b1; tick(); frame_end = 1'b0;
            repeat (100) tick();
        end else begin
            repeat (5) tick();
        end
        req_valid = 2'b01; req_row = {4'd1, 4'd2}; req_col = {4'd3, 4'd4}; req_den = 4'b1001;
        rst = 1'b1;
        #1;
        chk("arst_front", front_sel, 0);
        chk("arst_busy", busy, 0);
        chk("arst_ack", swap_ack, 0);
        chk("arst_ready", req_ready, 0);
        chk("arst_rd", rd_den, 0);
        tick();
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_grant", req_ready, 1);
        tick();
        req_valid = 2'b00;

        // Randomized traffic with payload held until granted.
        for (int k = 0; k < 3000; k++) begin
            @(negedge clk);
            gv = req_ready;
            tick();
            for (int i = 0; i < 2; i++)
                if (!req_valid[i] || gv[i]) begin
                    req_valid[i]      = 1'($urandom_range(0, 1));
                    req_row[i*4 +: 4] = 4'($urandom_range(0, 15));
                    req_col[i*4 +: 4] = 4'($urandom_range(0, 15));
                    req_den[i*2 +: 2] = 2'($urandom_range(0, 3));
                end
            swap_req  = ($urandom_range(0, 19) == 0);
            frame_end = ($urandom_range(0, 15) == 0);
            rd_row    = 4'($urandom_range(0, 15));
            rd_col    = 4'($urandom_range(0, 15));
        end
        req_valid = '0; swap_req = 1'b0; frame_end = 1'b0;
        repeat (3) tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
